// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller and its datapath.
// Opcode/funct values, ALU operation codes, FSM state and PC source encodings.
// Instruction classes and the decoder result struct used between mc_decode and the FSM.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_SLT  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [4:0] alu_ctrl;
        logic       extend;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decode into instruction class, ALU op, extend mode, illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; consumer samples it when the FSM needs it.
module mc_decode
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    // Table lookup; anything not listed is illegal. Branches sign-extend their offset.
    always_comb begin
        dec = '{cls: CL_RALU, alu_ctrl: ALU_ADD, extend: 1'b0, illegal: 1'b0};
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  dec.alu_ctrl = ALU_ADD;
                    FN_SUB:  dec.alu_ctrl = ALU_SUB;
                    FN_AND:  dec.alu_ctrl = ALU_AND;
                    FN_OR:   dec.alu_ctrl = ALU_OR;
                    FN_SLT:  dec.alu_ctrl = ALU_SLT;
                    FN_SLL:  dec.alu_ctrl = ALU_SLL;
                    FN_SRL:  dec.alu_ctrl = ALU_SRL;
                    FN_JR:   dec.cls      = CL_JR;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            OP_ADDI: begin dec.cls = CL_IALU; dec.extend = 1'b1; end
            OP_ANDI: begin dec.cls = CL_IALU; dec.alu_ctrl = ALU_AND; end
            OP_ORI:  begin dec.cls = CL_IALU; dec.alu_ctrl = ALU_OR;  end
            OP_LW:   begin dec.cls = CL_LW;   dec.extend = 1'b1; end
            OP_SW:   begin dec.cls = CL_SW;   dec.extend = 1'b1; end
            OP_BEQ:  begin dec.cls = CL_BEQ;  dec.alu_ctrl = ALU_SUB; dec.extend = 1'b1; end
            OP_BNE:  begin dec.cls = CL_BNE;  dec.alu_ctrl = ALU_SUB; dec.extend = 1'b1; end
            OP_J:    dec.cls = CL_J;
            OP_JAL:  dec.cls = CL_JAL;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with run gating, illegal/timeout trap and retire counter.
// Latency: branch/jump 3 cycles, R/I-ALU 4, sw 4+waits, lw 5+waits.
// Backpressure: MEM state stalls until mem_ready; FETCH holds while run=0.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int RETIRE_W    = 32,
    parameter int MEM_TIMEOUT = 16
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                PCtoReg,
    output logic                MemtoReg,
    output logic                mem_req,
    output logic                MemWrite,
    output logic                ALUSrcA,
    output logic                ALUSrcB,
    output logic                Extend,
    output logic [4:0]          ALUControl,
    output logic [2:0]          state,
    output logic                instr_done,
    output logic                trap,
    output logic [RETIRE_W-1:0] instret
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   mem_wait_q, mem_wait_d;
    logic [RETIRE_W-1:0] instret_q, instret_d;
    dec_t                dec;

    logic       pc_write, ir_write, reg_write, reg_dst, pc_to_reg, mem_to_reg;
    logic       mem_req_c, mem_write, alu_drive, done;
    logic [1:0] pc_src;

    mc_decode u_decode (
        .op   (op),
        .func (func),
        .dec  (dec)
    );

    // State, MEM wait counter and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            mem_wait_q <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            mem_wait_q <= mem_wait_d;
            instret_q  <= instret_d;
        end
    end

    // Next state and Moore control decode of state + op/func.
    always_comb begin
        state_d    = state_q;
        mem_wait_d = mem_wait_q;
        pc_write   = 1'b0;
        pc_src     = PCSRC_PLUS4;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        pc_to_reg  = 1'b0;
        mem_to_reg = 1'b0;
        mem_req_c  = 1'b0;
        mem_write  = 1'b0;
        alu_drive  = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = dec.illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                alu_drive = 1'b1;
                state_d   = S_FETCH;
                case (dec.cls)
                    CL_RALU, CL_IALU: state_d = S_WB;
                    CL_LW, CL_SW:     state_d = S_MEM;
                    CL_BEQ: begin
                        pc_write = zero;
                        pc_src   = PCSRC_BRANCH;
                        done     = 1'b1;
                    end
                    CL_BNE: begin
                        pc_write = ~zero;
                        pc_src   = PCSRC_BRANCH;
                        done     = 1'b1;
                    end
                    CL_J: begin
                        pc_write = 1'b1;
                        pc_src   = PCSRC_JUMP;
                        done     = 1'b1;
                    end
                    CL_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = PCSRC_JUMP;
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                        done      = 1'b1;
                    end
                    CL_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PCSRC_RS;
                        done     = 1'b1;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                alu_drive = 1'b1;
                mem_req_c = 1'b1;
                mem_write = (dec.cls == CL_SW);
                if (mem_ready) begin
                    mem_wait_d = '0;
                    if (dec.cls == CL_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        done    = 1'b1;
                    end
                end else if (MEM_TIMEOUT != 0) begin
                    if (mem_wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d    = S_TRAP;
                        mem_wait_d = '0;
                    end else begin
                        mem_wait_d = mem_wait_q + 1'b1;
                    end
                end
            end
            S_WB: begin
                alu_drive  = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = (dec.cls == CL_RALU);
                mem_to_reg = (dec.cls == CL_LW);
                done       = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        instret_d = instret_q + RETIRE_W'(done);
    end

    // There is no ALU result register in the datapath, so the ALU selects stay
    // driven from EXEC through MEM and WB. Enables are forced low during reset.
    assign ALUControl = alu_drive ? dec.alu_ctrl : ALU_ADD;
    assign ALUSrcA    = alu_drive & (dec.cls == CL_RALU) &
                        ((dec.alu_ctrl == ALU_SLL) | (dec.alu_ctrl == ALU_SRL));
    assign ALUSrcB    = alu_drive & ((dec.cls == CL_IALU) | (dec.cls == CL_LW) | (dec.cls == CL_SW));
    assign Extend     = alu_drive & dec.extend;
    assign PCWrite    = pc_write   & ~rst;
    assign PCSrc      = pc_src;
    assign IRWrite    = ir_write   & ~rst;
    assign RegWrite   = reg_write  & ~rst;
    assign RegDst     = reg_dst;
    assign PCtoReg    = pc_to_reg  & ~rst;
    assign MemtoReg   = mem_to_reg;
    assign mem_req    = mem_req_c  & ~rst;
    assign MemWrite   = mem_write  & ~rst;
    assign instr_done = done       & ~rst;
    assign state      = state_q;
    assign trap       = (state_q == S_TRAP);
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream checked cycle-by-cycle against a per-instruction trace model.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    localparam int RW  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst, run, zero, mem_ready;
    logic [5:0] op, func;
    logic PCWrite, IRWrite, RegWrite, RegDst, PCtoReg, MemtoReg, mem_req, MemWrite;
    logic ALUSrcA, ALUSrcB, Extend, instr_done, trap;
    logic [1:0] PCSrc;
    logic [4:0] ALUControl;
    logic [2:0] state;
    logic [RW-1:0] instret;

    multicycle_ctrl #(.RETIRE_W(RW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .run(run), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCtoReg(PCtoReg), .MemtoReg(MemtoReg),
        .mem_req(mem_req), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .Extend(Extend), .ALUControl(ALUControl), .state(state), .instr_done(instr_done),
        .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw; logic [1:0] pcsrc; logic irw, rw, rdst, pc2r, m2r, mreq, mw, asa, asb, ext;
        logic [4:0] aluc; logic [2:0] st; logic done, trap; logic [RW-1:0] ir;
    } ov_t;
    typedef struct { ov_t v; string tag; } rec_t;
    // cls: 0 R-ALU, 1 I-ALU, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 jal, 8 jr
    typedef struct { logic [5:0] op; logic [5:0] fn; int cls; logic [4:0] alu; bit ext; string nm; } ins_t;

    rec_t exp_q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, mcnt = 0;
    ov_t  got;

    assign got = {PCWrite, PCSrc, IRWrite, RegWrite, RegDst, PCtoReg, MemtoReg, mem_req,
                  MemWrite, ALUSrcA, ALUSrcB, Extend, ALUControl, state, instr_done, trap, instret};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] g, logic [31:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, g, e);
        end
    endtask

    // Compare process: one expected record per pushed cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t r;
            r = exp_q.pop_front();
            check(r.tag, 32'(got), 32'(r.v));
        end
    end

    function automatic ov_t blank(logic [2:0] st);
        ov_t o = '0;
        o.st   = st;
        o.trap = (st == 3'd7);
        o.ir   = mcnt[RW-1:0];
        return o;
    endfunction

    function automatic ins_t mk(int k);
        ins_t t;
        t.fn = 6'($urandom); t.ext = 1'b0; t.alu = ALU_ADD;
        case (k)
            0:  begin t.nm = "add";  t.op = 6'h00; t.fn = 6'h20; t.cls = 0; end
            1:  begin t.nm = "sub";  t.op = 6'h00; t.fn = 6'h22; t.cls = 0; t.alu = ALU_SUB; end
            2:  begin t.nm = "and";  t.op = 6'h00; t.fn = 6'h24; t.cls = 0; t.alu = ALU_AND; end
            3:  begin t.nm = "or";   t.op = 6'h00; t.fn = 6'h25; t.cls = 0; t.alu = ALU_OR;  end
            4:  begin t.nm = "slt";  t.op = 6'h00; t.fn = 6'h2A; t.cls = 0; t.alu = ALU_SLT; end
            5:  begin t.nm = "sll";  t.op = 6'h00; t.fn = 6'h00; t.cls = 0; t.alu = ALU_SLL; end
            6:  begin t.nm = "srl";  t.op = 6'h00; t.fn = 6'h02; t.cls = 0; t.alu = ALU_SRL; end
            7:  begin t.nm = "jr";   t.op = 6'h00; t.fn = 6'h08; t.cls = 8; end
            8:  begin t.nm = "addi"; t.op = 6'h08; t.cls = 1; t.ext = 1'b1; end
            9:  begin t.nm = "andi"; t.op = 6'h0C; t.cls = 1; t.alu = ALU_AND; end
            10: begin t.nm = "ori";  t.op = 6'h0D; t.cls = 1; t.alu = ALU_OR; end
            11: begin t.nm = "lw";   t.op = 6'h23; t.cls = 2; t.ext = 1'b1; end
            12: begin t.nm = "sw";   t.op = 6'h2B; t.cls = 3; t.ext = 1'b1; end
            13: begin t.nm = "beq";  t.op = 6'h04; t.cls = 4; t.alu = ALU_SUB; t.ext = 1'b1; end
            14: begin t.nm = "bne";  t.op = 6'h05; t.cls = 5; t.alu = ALU_SUB; t.ext = 1'b1; end
            15: begin t.nm = "j";    t.op = 6'h02; t.cls = 6; end
            default: begin t.nm = "jal"; t.op = 6'h03; t.cls = 7; end
        endcase
        return t;
    endfunction

    // ALU selects an instruction presents while it is executing.
    function automatic ov_t with_alu(ov_t e, ins_t in);
        e.aluc = in.alu;
        e.ext  = in.ext;
        e.asa  = (in.cls == 0) && (in.fn == 6'h00 || in.fn == 6'h02);
        e.asb  = (in.cls == 1) || (in.cls == 2) || (in.cls == 3);
        return e;
    endfunction

    task automatic push(ov_t e, string t);
        rec_t r;
        r.v = e; r.tag = t;
        exp_q.push_back(r);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        run = 1'b0; op = 6'($urandom); func = 6'($urandom); mem_ready = 1'($urandom);
        push(blank(3'd0), "idle");
        tick();
    endtask

    task automatic trap_cycles(int n);
        for (int i = 0; i < n; i++) begin
            run = 1'b1; mem_ready = 1'($urandom); zero = 1'($urandom);
            push(blank(3'd7), "trap hold");
            tick();
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; run = 1'b1; mem_ready = 1'b1; mcnt = 0;
        push(blank(3'd0), "in reset");
        tick();
        rst = 1'b0;
    endtask

    // One instruction: fetch, decode, then the phases its class implies.
    task automatic do_instr(ins_t in, bit z, int waits, bit abort, output int ncyc);
        ov_t e;
        ncyc = 0;
        run = 1'b1; op = 6'($urandom); func = 6'($urandom); zero = 1'($urandom);
        mem_ready = 1'($urandom);
        e = blank(3'd0); e.irw = 1'b1; e.pcw = 1'b1;
        push(e, {in.nm, " fetch"}); tick(); ncyc++;
        op = in.op; func = in.fn; zero = z; run = 1'($urandom); mem_ready = 1'($urandom);
        push(blank(3'd1), {in.nm, " decode"}); tick(); ncyc++;
        e = with_alu(blank(3'd2), in);
        mem_ready = 1'($urandom);
        if (in.cls >= 4) begin
            e.done = 1'b1;
            case (in.cls)
                4: begin e.pcw = z;  e.pcsrc = 2'b01; end
                5: begin e.pcw = !z; e.pcsrc = 2'b01; end
                6: begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
                7: begin e.pcw = 1'b1; e.pcsrc = 2'b10; e.rw = 1'b1; e.pc2r = 1'b1; end
                default: begin e.pcw = 1'b1; e.pcsrc = 2'b11; end
            endcase
            push(e, {in.nm, " exec"}); tick(); ncyc++; mcnt++;
            return;
        end
        push(e, {in.nm, " exec"}); tick(); ncyc++;
        if (in.cls == 2 || in.cls == 3) begin
            for (int w = 0; w < 64; w++) begin
                bit rdy;
                rdy = (w >= waits);
                mem_ready = rdy; run = 1'($urandom);
                e = with_alu(blank(3'd3), in);
                e.mreq = 1'b1; e.mw = (in.cls == 3);
                if (rdy && in.cls == 3) e.done = 1'b1;
                push(e, {in.nm, " mem"});
                if (abort) begin
                    mem_ready = 1'b0;
                    @(negedge clk); #2;
                    rst = 1'b1; mcnt = 0;
                    #1;
                    check("abort mem_req", 32'(mem_req), 32'd0);
                    check("abort MemWrite", 32'(MemWrite), 32'd0);
                    check("abort state", 32'(state), 32'd0);
                    tick();
                    rst = 1'b0;
                    return;
                end
                tick(); ncyc++;
                if (rdy) break;
                if (w + 1 == TMO) return;
            end
            if (in.cls == 3) begin
                mcnt++;
                return;
            end
        end
        mem_ready = 1'($urandom);
        e = with_alu(blank(3'd4), in);
        e.rw = 1'b1; e.rdst = (in.cls == 0); e.m2r = (in.cls == 2); e.done = 1'b1;
        push(e, {in.nm, " wb"}); tick(); ncyc++; mcnt++;
    endtask

    initial begin
        int n;
        ins_t in;
        rst = 1'b1; run = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        tick();
        push(blank(3'd0), "in reset"); tick();
        push(blank(3'd0), "in reset"); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) idle();
        check("reset instret", 32'(instret), 32'd0);
        check("reset state", 32'(state), 32'd0);

        do_instr(mk(0), 1'b0, 0, 1'b0, n);
        check("add latency", n, 4);
        check("add instret", 32'(instret), 32'd1);
        do_instr(mk(11), 1'b0, 3, 1'b0, n);
        check("lw 3-wait latency", n, 8);
        do_instr(mk(12), 1'b0, 0, 1'b0, n);
        check("sw latency", n, 4);
        do_instr(mk(13), 1'b1, 0, 1'b0, n);
        check("beq latency", n, 3);
        do_instr(mk(13), 1'b0, 0, 1'b0, n);
        do_instr(mk(14), 1'b1, 0, 1'b0, n);
        do_instr(mk(16), 1'b0, 0, 1'b0, n);
        check("instret after 7", 32'(instret), 32'd7);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) idle();
            end
            in = mk(int'($urandom_range(0, 16)));
            do_instr(in, 1'($urandom), int'($urandom_range(0, 3)), 1'b0, n);
        end

        // Illegal opcode, then illegal R-type funct.
        in = mk(0); in.op = 6'h3F; in.nm = "illop";
        run = 1'b1;
        push(((blank(3'd0) | ov_t'(0)) ^ '0) | {1'b1, 2'b00, 1'b1, 23'd0} , "illop fetch");
        tick();
        op = 6'h3F; func = 6'($urandom);
        push(blank(3'd1), "illop decode"); tick();
        trap_cycles(4);
        check("illegal op trap", 32'(trap), 32'd1);
        do_reset();
        check("post reset trap", 32'(trap), 32'd0);
        run = 1'b1; op = 6'($urandom);
        push(((blank(3'd0)) | {1'b1, 2'b00, 1'b1, 23'd0}), "illfn fetch");
        tick();
        op = 6'h00; func = 6'h3F;
        push(blank(3'd1), "illfn decode"); tick();
        trap_cycles(3);
        do_reset();

        // Memory timeout: 16 wait cycles in MEM, then TRAP.
        do_instr(mk(11), 1'b0, 1000, 1'b0, n);
        check("timeout cycles", n, 19);
        trap_cycles(3);
        check("timeout trap", 32'(trap), 32'd1);
        do_reset();

        // Async reset in the middle of a store.
        do_instr(mk(12), 1'b0, 5, 1'b1, n);
        check("abort instret", 32'(instret), 32'd0);

        // Counter wrap.
        for (int i = 0; i < 15; i++) do_instr(mk(15), 1'b0, 0, 1'b0, n);
        check("instret max", 32'(instret), 32'd15);
        do_instr(mk(15), 1'b0, 0, 1'b0, n);
        check("instret wrap", 32'(instret), 32'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
